// File: rtl/adcrecv_pkg.sv
// Shared definitions for the ADC receive engine: frame geometry, FSM states
// and a helper that maps a bit index onto a sample field.
package adcrecv_pkg;

  localparam int ADC_FRAME_BITS = 34;
  localparam int ADC_SAMPLE_W   = 14;
  localparam int ADC_CH0_FIRST  = 2;
  localparam int ADC_CH1_FIRST  = 18;

  // Bit counter covers indices 0..33.
  localparam int BIT_W = 6;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ADC_FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] CH0_LO   = BIT_W'(ADC_CH0_FIRST);
  localparam logic [BIT_W-1:0] CH1_LO   = BIT_W'(ADC_CH1_FIRST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // True when bit index idx falls inside the sample field starting at lo.
  function automatic logic in_field(input logic [BIT_W-1:0] idx,
                                    input logic [BIT_W-1:0] lo);
    return (idx >= lo) && (idx < lo + BIT_W'(ADC_SAMPLE_W));
  endfunction

endpackage

// File: rtl/adcrecv_sckgen.sv
// SPI clock generator: divides CLK50MHZ into a half-period tick and produces
// the free-running serial clock plus single-cycle edge strobes. Everything is
// held cleared while en is low so each frame starts from a known phase.
module adcrecv_sckgen #(
  parameter int SCK_DIV = 2
) (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb,
  output logic period_end_stb
);

  localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       half_end;

  // Divider count and clock phase for the next cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    half_end = en && (cnt_q == DIV_LAST);
    if (!en) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider state register with synchronous reset.
  always_ff @(posedge CLK50MHZ) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (RST) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck            = sck_q;
  assign rise_stb       = half_end & ~sck_q;
  assign fall_stb       = half_end &  sck_q;
  // A bit period ends with the high half, i.e. on the falling edge.
  assign period_end_stb = fall_stb;

endmodule

// File: rtl/adcrecv.sv
// SPI receive engine for a dual-channel 14-bit ADC. A trigger pulses AD_CONV
// for one SCK period, then 34 SCK periods shift the frame in; both samples are
// published together with a one-cycle adcdone pulse. All outputs are flops.
module adcrecv
  import adcrecv_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic                    CLK50MHZ,
  input  logic                    RST,
  input  logic                    adctrig,
  output logic                    adcbusy,
  output logic                    adcdone,
  output logic [ADC_SAMPLE_W-1:0] ch0,
  output logic [ADC_SAMPLE_W-1:0] ch1,
  output logic                    AD_CONV,
  output logic                    SPI_SCK,
  input  logic                    SPI_MISO
);

  state_e                  state_q, state_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [ADC_SAMPLE_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [ADC_SAMPLE_W-1:0] ch0_q, ch0_d, ch1_q, ch1_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    conv_q, conv_d;
  logic                    sck_q, sck_d;

  logic gen_en, gen_sck, rise_stb, fall_stb, period_end_stb;

  // The divider runs through CONV as well: its first full period times the
  // AD_CONV pulse, and SHIFT then starts on a fresh period boundary.
  assign gen_en = (state_q == ST_CONV) || (state_q == ST_SHIFT);

  adcrecv_sckgen #(
    .SCK_DIV (SCK_DIV)
  ) u_sckgen (
    .CLK50MHZ       (CLK50MHZ),
    .RST            (RST),
    .en             (gen_en),
    .sck            (gen_sck),
    .rise_stb       (rise_stb),
    .fall_stb       (fall_stb),
    .period_end_stb (period_end_stb)
  );

  // Next state, bit counter, shadow shifting and output register inputs.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    ch0_d   = ch0_q;
    ch1_d   = ch1_q;

    case (state_q)
      ST_IDLE: begin
        if (adctrig) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (period_end_stb) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // MISO is sampled on the same edge that drives SPI_SCK high.
        if (rise_stb) begin
          if (in_field(bit_q, CH0_LO)) sh0_d = {sh0_q[ADC_SAMPLE_W-2:0], SPI_MISO};
          if (in_field(bit_q, CH1_LO)) sh1_d = {sh1_q[ADC_SAMPLE_W-2:0], SPI_MISO};
        end
        if (period_end_stb) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_DONE;
            bit_d   = '0;
            // Publish both samples on the edge that enters DONE so they are
            // valid in the adcdone cycle and never seen half-updated.
            ch0_d   = sh0_q;
            ch1_d   = sh1_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = adctrig ? ST_CONV : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so pins change cleanly on
    // the same edge as the state transition.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    conv_d = (state_d == ST_CONV);
    sck_d  = (state_d == ST_SHIFT) && (rise_stb || (gen_sck && !fall_stb));
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      ch0_q   <= '0;
      ch1_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      sck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
      sck_q   <= sck_d;
    end
  end

  assign adcbusy = busy_q;
  assign adcdone = done_q;
  assign ch0     = ch0_q;
  assign ch1     = ch1_q;
  assign AD_CONV = conv_q;
  assign SPI_SCK = sck_q;

endmodule

// File: tb/tb_adcrecv.sv
// Bench for adcrecv: two instances (SCK_DIV=2 and SCK_DIV=1) each fed by a
// behavioural ADC that serialises a 34-bit frame built from its sample pair.
// Expected data comes from a per-instance queue of the samples the ADC sent;
// expected timing comes from 1+70*SCK_DIV arithmetic.
module tb_adcrecv;

  localparam int DIV [2] = '{2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        trig [2] = '{1'b0, 1'b0};
  logic        busy [2];
  logic        done [2];
  logic        conv [2];
  logic        sck  [2];
  logic        miso [2] = '{1'b1, 1'b1};
  logic [13:0] ch0  [2];
  logic [13:0] ch1  [2];

  // Samples the ADC model will present in its next frame.
  logic [13:0] fix0 [2]      = '{14'h0, 14'h0};
  logic [13:0] fix1 [2]      = '{14'h0, 14'h0};
  logic        rand_mode [2] = '{1'b0, 1'b0};

  int cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;

  int   done_n     [2] = '{0, 0};
  int   done_last  [2] = '{0, 0};
  int   conv_first [2] = '{0, 0};
  int   conv_hi    [2] = '{0, 0};
  int   rises      [2] = '{0, 0};
  logic conv_prev  [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adcrecv #(.SCK_DIV(2)) u_dut0 (
    .CLK50MHZ (clk),     .RST     (rst),     .adctrig (trig[0]),
    .adcbusy  (busy[0]), .adcdone (done[0]), .ch0     (ch0[0]),
    .ch1      (ch1[0]),  .AD_CONV (conv[0]), .SPI_SCK (sck[0]),
    .SPI_MISO (miso[0])
  );

  adcrecv #(.SCK_DIV(1)) u_dut1 (
    .CLK50MHZ (clk),     .RST     (rst),     .adctrig (trig[1]),
    .adcbusy  (busy[1]), .adcdone (done[1]), .ch0     (ch0[1]),
    .ch1      (ch1[1]),  .AD_CONV (conv[1]), .SPI_SCK (sck[1]),
    .SPI_MISO (miso[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mdl
    logic [33:0] frame = '1;
    int          idx   = 0;
    logic [27:0] exp_q [$];
    logic [13:0] s0, s1;

    // ADC: latch a frame at conversion start, advance one bit per SCK fall.
    always @(posedge conv[g] or negedge sck[g]) begin
      if (conv[g]) begin
        s0 = rand_mode[g] ? 14'($urandom) : fix0[g];
        s1 = rand_mode[g] ? 14'($urandom) : fix1[g];
        frame = {2'b11, s0, 2'b11, s1, 2'b11};
        exp_q.push_back({s0, s1});
        idx = 0;
      end else if (idx < 33) begin
        idx++;
      end
      miso[g] = frame[33 - idx];
    end

    always @(posedge sck[g]) rises[g]++;

    // Monitor: pulse timing and data checked against the ADC's sent samples.
    always @(negedge clk) begin
      logic [27:0] e;
      if (rst) begin
        exp_q.delete();
      end else begin
        if (conv[g] && !conv_prev[g]) conv_first[g] = cyc;
        if (conv[g]) conv_hi[g]++;
        if (done[g]) begin
          done_n[g]++;
          done_last[g] = cyc;
          if (exp_q.size() == 0) begin
            check($sformatf("done_spurious%0d", g), 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("ch0_%0d", g), 32'(ch0[g]), 32'(e[27:14]));
            check($sformatf("ch1_%0d", g), 32'(ch1[g]), 32'(e[13:0]));
          end
        end
      end
      conv_prev[g] = conv[g];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One triggered frame on instance 0; optional extra trigger while busy.
  task automatic one_frame(input logic [13:0] a, input logic [13:0] b, input int extra_at);
    int t0, d0, r0, h0;
    fix0[0] = a;
    fix1[0] = b;
    tick();
    t0 = cyc; d0 = done_n[0]; r0 = rises[0]; h0 = conv_hi[0];
    trig[0] = 1'b1;
    while (cyc < t0 + 142) begin
      tick();
      trig[0] = (extra_at > 0) && (cyc == t0 + extra_at);
      if (cyc == t0 + 140) check("done_early", 32'(done[0]), 0);
      if (cyc == t0 + 141) check("busy_in_done", 32'(busy[0]), 1);
    end
    check("busy_after", 32'(busy[0]), 0);
    check("done_edge", done_last[0] - t0, 141);
    check("done_count", done_n[0] - d0, 1);
    check("conv_first", conv_first[0] - t0, 1);
    check("conv_len", conv_hi[0] - h0, 4);
    check("sck_rises", rises[0] - r0, 34);
  endtask

  // Trigger held high on instance g: fixed period, data checked by monitor.
  task automatic continuous(input int g);
    int t0, prev, base, n;
    rand_mode[g] = 1'b1;
    tick();
    t0 = cyc; prev = t0; base = done_n[g];
    trig[g] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (done_n[g] == base + k && n < 400) begin tick(); n++; end
      check($sformatf("period%0d_%0d", g, k), done_last[g] - prev, 1 + 70 * DIV[g]);
      prev = done_last[g];
    end
    trig[g] = 1'b0;
    n = 0;
    while (busy[g] && n < 400) begin tick(); n++; end
    check($sformatf("cont_idle%0d", g), 32'(busy[g]), 0);
    rand_mode[g] = 1'b0;
  endtask

  initial begin
    int hi, t0, d0;
    repeat (5) tick();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_busy%0d", g), 32'(busy[g]), 0);
      check($sformatf("rst_done%0d", g), 32'(done[g]), 0);
      check($sformatf("rst_ch0_%0d", g), 32'(ch0[g]), 0);
      check($sformatf("rst_ch1_%0d", g), 32'(ch1[g]), 0);
      check($sformatf("rst_conv%0d", g), 32'(conv[g]), 0);
      check($sformatf("rst_sck%0d", g), 32'(sck[g]), 0);
    end
    rst = 1'b0;
    hi = 0;
    repeat (200) begin
      tick();
      if (sck[0] || conv[0] || sck[1] || conv[1] || busy[0] || busy[1]) hi++;
    end
    check("idle_quiet", hi, 0);

    one_frame(14'h1ABC, 14'h2345, 0);
    one_frame(14'h2000, 14'h3FFF, 0);
    check("ch0_sign", 32'(ch0[0][13]), 1);
    check("ch1_sign", 32'(ch1[0][13]), 1);

    // Second trigger during SHIFT must be dropped.
    one_frame(14'($urandom), 14'($urandom), 60);
    d0 = done_n[0];
    repeat (150) tick();
    check("busy_trig_ignored", done_n[0] - d0, 0);

    for (int i = 0; i < 3; i++) one_frame(14'($urandom), 14'($urandom), 0);
    repeat (20) tick();
    check("ch_hold_nonzero", 32'(ch0[0] != 0 || ch1[0] != 0), 1);

    // Reset during bit index 10 (edges t0+45..t0+48, SCK rises at t0+47).
    fix0[0] = 14'h1555;
    fix1[0] = 14'h0AAA;
    tick();
    t0 = cyc; d0 = done_n[0];
    trig[0] = 1'b1;
    tick();
    trig[0] = 1'b0;
    while (cyc < t0 + 46) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_sck", 32'(sck[0]), 0);
    check("mid_rst_conv", 32'(conv[0]), 0);
    check("mid_rst_busy", 32'(busy[0]), 0);
    check("mid_rst_ch0", 32'(ch0[0]), 0);
    check("mid_rst_ch1", 32'(ch1[0]), 0);
    repeat (200) tick();
    check("mid_rst_no_done", done_n[0] - d0, 0);
    one_frame(14'($urandom), 14'($urandom), 0);

    continuous(0);
    continuous(1);

    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/adcrecv.md
Name: adcrecv

Overview:
- SPI receive engine for the board's dual-channel 14-bit ADC (LTC1407A-style framing); the acquisition-side counterpart of dacsend.
- On each trigger it pulses AD_CONV, clocks one 34-bit frame in on SPI_MISO, and presents both channel samples with a one-cycle done pulse.
- Runs entirely on CLK50MHZ and generates its own SPI_SCK through an internal divider.

Parameters:
- SCK_DIV, 2, CLK50MHZ cycles per SPI_SCK half-period (default gives 12.5 MHz); legal range 1..255.

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz
- RST  in  1  reset, synchronous, active-high
- adctrig  in  1  conversion request, sampled every clock
- adcbusy  out  1  high from trigger acceptance until the adcdone cycle, inclusive
- adcdone  out  1  one-cycle pulse; ch0/ch1 are valid from this cycle onward
- ch0  out  14  channel 0 sample, two's complement
- ch1  out  14  channel 1 sample, two's complement
- AD_CONV  out  1  conversion start pulse to the ADC
- SPI_SCK  out  1  serial clock to the ADC, idles low
- SPI_MISO  in  1  serial data from the ADC, MSB first

Behaviour:
- Clock and reset: one clock, CLK50MHZ. RST is synchronous and active-high.
- Reset values: state IDLE, adcbusy=0, adcdone=0, ch0=0, ch1=0, AD_CONV=0, SPI_SCK=0, all counters 0.
- Internal strobes: a divider counter 0..SCK_DIV-1 produces a half-period tick. It runs only in CONV and SHIFT and is cleared in IDLE and DONE.
- IDLE:
  - adctrig=1 -> go to CONV on the next edge and set adcbusy=1.
  - adctrig=0 -> stay in IDLE.
- CONV:
  - AD_CONV=1 and SPI_SCK=0 for exactly 2*SCK_DIV clocks.
  - Then AD_CONV=0 and go to SHIFT.
- SHIFT:
  - 34 bit periods, indexed 0..33. Each period is SPI_SCK low for SCK_DIV clocks, then high for SCK_DIV clocks.
  - SPI_MISO is captured on the clock edge where SPI_SCK goes 0->1.
  - Bit indices 2..15 shift into the ch0 shadow register, MSB first.
  - Bit indices 18..31 shift into the ch1 shadow register, MSB first.
  - Bit indices 0, 1, 16, 17, 32 and 33 are discarded; the ADC tristates these.
  - After the high half of bit 33, SPI_SCK=0 and go to DONE.
- DONE (one clock):
  - Copy the shadow registers into ch0/ch1 atomically and set adcdone=1.
  - If adctrig=1 in this cycle -> go straight to CONV (back-to-back; adcbusy stays 1).
  - Otherwise -> go to IDLE, and adcbusy drops on the next cycle.
- Latency: adctrig sampled at edge 0 -> AD_CONV rises at edge 1 -> adcdone at edge 1+70*SCK_DIV (141 at default).
- Back-to-back period with adctrig held high: 1+70*SCK_DIV clocks.
- adctrig while busy (CONV/SHIFT): ignored, not queued.
- ch0/ch1 hold their last values between conversions; no partial update ever reaches them.
- RST mid-frame:
  - All outputs go to their reset values on that edge: SPI_SCK=0, AD_CONV=0, ch0/ch1=0.
  - No adcdone pulse is issued.
  - adctrig is honoured again from the first non-reset cycle.
- RST and adctrig in the same cycle: RST wins.

Decomposition:
- Shared include adc_defs.vh holds:
  - ADC_FRAME_BITS=34, ADC_SAMPLE_W=14, ADC_CH0_FIRST=2, ADC_CH1_FIRST=18
  - state encodings IDLE/CONV/SHIFT/DONE
- One sub-module, sckgen:
  - ports CLK50MHZ, RST, en, with parameter SCK_DIV
  - outputs sck, rise_stb, fall_stb, period_end_stb
  - adcrecv owns only the FSM, bit counter and shift registers.

Test Plan:
- Bench: an ADC model drives SPI_MISO after each SPI_SCK falling edge and presents fixed samples.
- Reset: hold RST for 5 clocks -> all outputs 0; SPI_SCK and AD_CONV stay low for 200 idle clocks.
- Single conversion: model ch0=14'h1ABC, ch1=14'h2345, don't-care bits driven 1; adctrig pulse at edge 0 ->
  - AD_CONV high for edges 1..4
  - exactly 34 SPI_SCK rising edges
  - adcdone at edge 141 only
  - ch0=14'h1ABC, ch1=14'h2345
- Sign extremes: model ch0=14'h2000, ch1=14'h3FFF -> outputs 14'h2000 and 14'h3FFF, with bit 13 set on both.
- Trigger while busy: second adctrig pulse at edge 60 -> exactly one adcdone, and adcbusy low at edge 142.
- Reset mid-frame: RST at bit index 10 ->
  - next cycle SPI_SCK=0, AD_CONV=0, ch0/ch1=0
  - no adcdone
  - a fresh trigger then returns correct data 141 clocks later.
- Continuous: adctrig held high with model samples changing per frame -> adcdone every 141 clocks; each ch0/ch1 pair matches its frame; SCK_DIV=1 rerun gives a 71-clock period.
